// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem request, presents one instruction to decode.
// Latency: 1 cycle from imem_ack to if_valid; redirect shows up on pc_update/imem_addr the next cycle.
// Backpressure: stall holds a valid entry in a one-deep output buffer and suppresses imem_req until it is consumed.
// Optional: define FETCH_ALIGN_CHK_EN to trap misaligned branch targets into the error state.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_ir,
  output logic [31:0] if_pc,
  output logic        pc_update,
  output logic [31:0] pc_i,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        vld_nxt;
  logic [31:0] ir_nxt, ifpc_nxt, pci_nxt;
  logic        pcu_nxt;
  logic [31:0] br_tgt;
  logic        br_bad;

  // Redirect targets are always forced to a word boundary.
  assign br_tgt = br_target & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHK_EN
  assign br_bad = br_valid && (br_target[1:0] != 2'b00);
`else
  assign br_bad = 1'b0;
`endif

  // Never request while an unconsumed instruction is being held by decode.
  assign imem_req  = (state == REQ) && !(if_valid && stall);
  assign imem_addr = pc;
  assign fetch_err = (state == ERR);

  // Next-state and datapath: ERR is terminal, then branch, then stall, then ack.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wait_nxt  = wait_cnt;
    vld_nxt   = if_valid;
    ir_nxt    = if_ir;
    ifpc_nxt  = if_pc;
    pcu_nxt   = 1'b0;
    pci_nxt   = pc_i;
    if (state == ERR) begin
      vld_nxt = 1'b0;
    end else if (br_valid) begin
      if (br_bad) begin
        state_nxt = ERR;
        vld_nxt   = 1'b0;
      end else begin
        // Flush: any ack arriving alongside the branch is dropped.
        state_nxt = REQ;
        pc_nxt    = br_tgt;
        pcu_nxt   = 1'b1;
        pci_nxt   = br_tgt;
        vld_nxt   = 1'b0;
        wait_nxt  = 8'd0;
      end
    end else begin
      case (state)
        IDLE: state_nxt = REQ;
        HOLD: begin
          // Decode takes the held entry this cycle, so the buffer empties.
          if (!stall) begin
            state_nxt = REQ;
            vld_nxt   = 1'b0;
          end
        end
        REQ: begin
          if (if_valid && stall) begin
            state_nxt = HOLD;
          end else if (imem_ack) begin
            ir_nxt   = imem_rdata;
            ifpc_nxt = pc;
            vld_nxt  = 1'b1;
            pc_nxt   = pc + 32'd4;
            wait_nxt = 8'd0;
          end else begin
            vld_nxt  = 1'b0;
            wait_nxt = wait_cnt + 8'd1;
            if (wait_nxt == MAX_WAIT_C) begin
              state_nxt = ERR;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, timeout counter and output buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      wait_cnt  <= 8'd0;
      if_valid  <= 1'b0;
      if_ir     <= 32'd0;
      if_pc     <= 32'd0;
      pc_update <= 1'b0;
      pc_i      <= 32'd0;
    end else begin
      pc        <= pc_nxt;
      wait_cnt  <= wait_nxt;
      if_valid  <= vld_nxt;
      if_ir     <= ir_nxt;
      if_pc     <= ifpc_nxt;
      pc_update <= pcu_nxt;
      pc_i      <= pci_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus random traffic against a behavioural model.
// Latency: n/a (stimulus applied on the falling edge, outputs sampled 1ns later).
// Backpressure: stall and imem_ack are driven directly and randomly.
module tb_fetch_ctrl;

  localparam int          MAX_WAIT = 15;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic        pc_update;
  logic [31:0] pc_i;
  logic        fetch_err;

  fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc),
    .pc_update(pc_update), .pc_i(pc_i), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: what decode and memory should observe.
  bit          m_started;   // first post-reset cycle has passed
  bit          m_err;       // watchdog or alignment trap fired
  bit          m_held;      // an entry was stalled and is waiting for decode
  bit          m_valid;
  logic [31:0] m_pc, m_ir, m_ifpc, m_pci;
  bit          m_pcu;
  int          m_waits;
  bit          auto_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_req();
    return m_started && !m_err && !m_held && !(m_valid && stall);
  endfunction

  task automatic model_reset();
    m_started = 0; m_err = 0; m_held = 0; m_valid = 0;
    m_pc = RESET_PC; m_ir = 32'd0; m_ifpc = 32'd0; m_pci = 32'd0;
    m_pcu = 0; m_waits = 0;
  endtask

  task automatic check_all();
    chk("imem_req",  32'(imem_req),  32'(exp_req()));
    chk("imem_addr", imem_addr,      m_pc);
    chk("if_valid",  32'(if_valid),  32'(m_valid));
    chk("if_pc",     if_pc,          m_ifpc);
    chk("if_ir",     if_ir,          m_ir);
    chk("pc_update", 32'(pc_update), 32'(m_pcu));
    chk("pc_i",      pc_i,           m_pci);
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    tgt = {br_target[31:2], 2'b00};
    m_pcu = 0;
    if (m_err) begin
      m_valid = 0;
    end else if (br_valid) begin
      m_started = 1;
      m_held = 0;
`ifdef FETCH_ALIGN_CHK_EN
      if (br_target[1:0] != 2'b00) begin
        m_err = 1;
        m_valid = 0;
      end else begin
        m_pc = tgt; m_pcu = 1; m_pci = tgt; m_valid = 0; m_waits = 0;
      end
`else
      m_pc = tgt; m_pcu = 1; m_pci = tgt; m_valid = 0; m_waits = 0;
`endif
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_held) begin
      if (!stall) begin
        m_held = 0;
        m_valid = 0;
      end
    end else if (m_valid && stall) begin
      m_held = 1;
    end else if (imem_ack) begin
      m_ir = imem_rdata; m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4; m_waits = 0;
    end else begin
      m_valid = 0;
      m_waits++;
      if (m_waits >= MAX_WAIT) m_err = 1;
    end
  endtask

  // One clock: called just after a falling edge with inputs already set.
  task automatic cyc();
    if (auto_rdata) imem_rdata = m_pc ^ 32'hA5A5_A5A5;
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
    br_valid = 1'b0; br_target = 32'd0; auto_rdata = 1'b1;
    model_reset();

    // Reset values while rst is held.
    #50;
    check_all();
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // Streaming with ack always high.
    imem_ack = 1'b1;
    for (int i = 0; i < 20 && !(m_valid && m_ifpc == 32'd8); i++) cyc();
    chk("reach_pc8", if_pc, 32'd8);
    chk("reach_ir8", if_ir, 32'h0000_0008 ^ 32'hA5A5_A5A5);

    // Stall three cycles: entry for pc 8 must be held.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold_pc", if_pc, 32'd8);
      chk("stall_hold_vld", 32'(if_valid), 32'd1);
    end
    stall = 1'b0;
    for (int i = 0; i < 5 && !exp_req(); i++) cyc();
    #1;
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'd12);
    cyc();
    chk("resume_pc", if_pc, 32'd12);

    // Redirect mid-stream.
    br_valid = 1'b1; br_target = 32'h0000_0104;
    cyc();
    br_valid = 1'b0;
    chk("br_pcu", 32'(pc_update), 32'd1);
    chk("br_pci", pc_i, 32'h104);
    chk("br_flush", 32'(if_valid), 32'd0);
    #1;
    chk("br_addr0", imem_addr, 32'h104);
    cyc();
    #1;
    chk("br_addr1", imem_addr, 32'h108);
    chk("br_pcu_once", 32'(pc_update), 32'd0);
    cyc();

    // Redirect while a valid entry is stalled, with a same-cycle ack.
    chk("pre_stall_vld", 32'(if_valid), 32'd1);
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_0104;
    cyc();
    stall = 1'b0; br_valid = 1'b0;
    chk("bs_flush", 32'(if_valid), 32'd0);
    chk("bs_pcu", 32'(pc_update), 32'd1);
    #1;
    chk("bs_addr", imem_addr, 32'h104);
    cyc();
    chk("bs_pc", if_pc, 32'h104);

    // Random traffic.
    auto_rdata = 1'b0;
    for (int i = 0; i < 400; i++) begin
      imem_ack   = ($urandom_range(0, 3) != 0);
      imem_rdata = $urandom;
      stall      = ($urandom_range(0, 3) == 0);
      br_valid   = ($urandom_range(0, 15) == 0);
      br_target  = $urandom & 32'hFFFF_FFFC;
      cyc();
    end
    auto_rdata = 1'b1; stall = 1'b0; imem_ack = 1'b1; br_valid = 1'b0;
    cyc();

    // Misaligned redirect target.
    br_valid = 1'b1; br_target = 32'h0000_0106;
    cyc();
    br_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_nopcu", 32'(pc_update), 32'd0);
`else
    chk("mis_pcu", 32'(pc_update), 32'd1);
    chk("mis_pci", pc_i, 32'h104);
    #1;
    chk("mis_addr", imem_addr, 32'h104);
`endif
    repeat (3) cyc();

    // Watchdog: no ack at all after reset.
    do_reset();
    imem_ack = 1'b0;
    repeat (MAX_WAIT) cyc();
    chk("to_not_yet", 32'(fetch_err), 32'd0);
    cyc();
    chk("to_err", 32'(fetch_err), 32'd1);
    br_valid = 1'b1; br_target = 32'h40; imem_ack = 1'b1;
    repeat (3) cyc();
    br_valid = 1'b0;
    #1;
    chk("to_sticky", 32'(fetch_err), 32'd1);
    chk("to_noreq", 32'(imem_req), 32'd0);
    chk("to_nopcu", 32'(pc_update), 32'd0);

    // Reset clears the sticky error.
    do_reset();
    chk("rst_clear", 32'(fetch_err), 32'd0);
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
